// File: rtl/mem_access_stage.sv
// MEM stage of the five-stage pipeline.
// Drives a single-port data-memory bus using a req/ready handshake.
// Stores are placed on the correct byte lanes; loads are formatted to byte, half or word.
// The pipeline is stalled until the access completes or times out.
module mem_access_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  MEM_Flag,
   input  logic [31:0] MEM_ALUResult,
   input  logic [31:0] MEM_WriteData,
   input  logic [4:0]  MEM_WriteReg,
   input  logic [1:0]  MEM_Size,
   input  logic        MEM_Unsigned,
   output logic [4:0]  MEM_FlagOut,
   output logic [31:0] MEM_ALUResultOut,
   output logic [4:0]  MEM_WriteRegOut,
   output logic [31:0] MEM_ReadDataMem,
   output logic        MEM_Stall,
   output logic [1:0]  MEM_Exc,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready
);

   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   localparam logic [1:0] ExcNone     = 2'b00;
   localparam logic [1:0] ExcMisalign = 2'b01;
   localparam logic [1:0] ExcTimeout  = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  exc_q, exc_d;

   logic        is_read, is_write, is_access, is_load;
   logic [1:0]  addr_lo;
   logic        size_byte, size_half, size_word;
   logic        misaligned;
   logic        timeout_hit;
   logic        req, stall;
   logic [3:0]  be_store;
   logic [31:0] wdata_store;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_fmt;

   // Decode the access type, its width and whether it is aligned.
   always_comb begin
      is_read    = MEM_Flag[2];
      is_write   = MEM_Flag[1];
      is_access  = is_read | is_write;
      // A read+write combination is treated as a write, so only a pure read counts as a load.
      is_load    = is_read & ~is_write;
      addr_lo    = MEM_ALUResult[1:0];
      size_byte  = (MEM_Size == 2'b00);
      size_half  = (MEM_Size == 2'b01);
      size_word  = ~size_byte & ~size_half;
      misaligned = (size_half & addr_lo[0]) | (size_word & (addr_lo != 2'b00));
   end

   // Compute store byte enables and replicate store data onto every lane.
   always_comb begin
      be_store    = 4'b1111;
      wdata_store = MEM_WriteData;
      unique case (MEM_Size)
         2'b00: begin
            be_store    = 4'b0001 << addr_lo;
            wdata_store = {4{MEM_WriteData[7:0]}};
         end
         2'b01: begin
            be_store    = 4'b0011 << {addr_lo[1], 1'b0};
            wdata_store = {2{MEM_WriteData[15:0]}};
         end
         default: begin
            be_store    = 4'b1111;
            wdata_store = MEM_WriteData;
         end
      endcase
   end

   // Select the addressed byte or half of the read word, then sign- or zero-extend it.
   always_comb begin
      byte_sel = dmem_rdata[7:0];
      unique case (addr_lo)
         2'b00:   byte_sel = dmem_rdata[7:0];
         2'b01:   byte_sel = dmem_rdata[15:8];
         2'b10:   byte_sel = dmem_rdata[23:16];
         default: byte_sel = dmem_rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      if (size_byte) begin
         load_fmt = {{24{~MEM_Unsigned & byte_sel[7]}}, byte_sel};
      end else if (size_half) begin
         load_fmt = {{16{~MEM_Unsigned & half_sel[15]}}, half_sel};
      end else begin
         load_fmt = dmem_rdata;
      end
   end

   // Access FSM: compute next state, the wait counter, and the captured result and exception.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      exc_d       = exc_q;
      req         = 1'b0;
      stall       = 1'b0;
      timeout_hit = (cnt_q == TimeoutCnt);
      unique case (state_q)
         StIdle: begin
            if (is_access) begin
               stall = 1'b1;
               if (misaligned) begin
                  // A misaligned access never reaches the bus.
                  state_d = StDone;
                  exc_d   = ExcMisalign;
                  rdata_d = '0;
               end else begin
                  req = 1'b1;
                  if (dmem_ready) begin
                     state_d = StDone;
                     exc_d   = ExcNone;
                     rdata_d = load_fmt;
                  end else begin
                     state_d = StBusy;
                     cnt_d   = 8'd1;
                  end
               end
            end
         end
         StBusy: begin
            stall = 1'b1;
            // The request is dropped in the final wait cycle.
            // A ready arriving in that same cycle still completes the access.
            req   = ~timeout_hit;
            if (dmem_ready) begin
               state_d = StDone;
               exc_d   = ExcNone;
               rdata_d = load_fmt;
            end else if (timeout_hit) begin
               state_d = StDone;
               exc_d   = ExcTimeout;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // State, counter, load-data and exception registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rdata_q <= '0;
         exc_q   <= ExcNone;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         exc_q   <= exc_d;
      end
   end

   // Bus and pipeline outputs.
   // Request and stall are gated by reset so that an abandoned access releases them at once.
   always_comb begin
      dmem_req         = req & rst_n;
      MEM_Stall        = stall & rst_n;
      dmem_we          = dmem_req & is_write;
      dmem_addr        = {MEM_ALUResult[31:2], 2'b00};
      dmem_be          = is_write ? be_store : 4'b1111;
      dmem_wdata       = wdata_store;
      MEM_ALUResultOut = MEM_ALUResult;
      MEM_WriteRegOut  = MEM_WriteReg;
      MEM_ReadDataMem  = rdata_q;
      MEM_Exc          = (state_q == StDone) ? exc_q : ExcNone;
      // A faulting load must not write back; a faulting store is simply not committed.
      MEM_FlagOut      = {MEM_Flag[4:1],
                          MEM_Flag[0] & ~((state_q == StDone) && (exc_q != ExcNone) && is_load)};
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage.
// Table-driven single-access vectors, followed by hand-written multi-cycle sequences.
module tb_mem_access_stage;

   logic        clk;
   logic        rst_n;
   logic [4:0]  MEM_Flag;
   logic [31:0] MEM_ALUResult;
   logic [31:0] MEM_WriteData;
   logic [4:0]  MEM_WriteReg;
   logic [1:0]  MEM_Size;
   logic        MEM_Unsigned;
   logic [4:0]  MEM_FlagOut;
   logic [31:0] MEM_ALUResultOut;
   logic [4:0]  MEM_WriteRegOut;
   logic [31:0] MEM_ReadDataMem;
   logic        MEM_Stall;
   logic [1:0]  MEM_Exc;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;

   int n_checks = 0;
   int n_pass   = 0;

   mem_access_stage #(.TIMEOUT(16)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .MEM_Flag         (MEM_Flag),
      .MEM_ALUResult    (MEM_ALUResult),
      .MEM_WriteData    (MEM_WriteData),
      .MEM_WriteReg     (MEM_WriteReg),
      .MEM_Size         (MEM_Size),
      .MEM_Unsigned     (MEM_Unsigned),
      .MEM_FlagOut      (MEM_FlagOut),
      .MEM_ALUResultOut (MEM_ALUResultOut),
      .MEM_WriteRegOut  (MEM_WriteRegOut),
      .MEM_ReadDataMem  (MEM_ReadDataMem),
      .MEM_Stall        (MEM_Stall),
      .MEM_Exc          (MEM_Exc),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_be          (dmem_be),
      .dmem_wdata       (dmem_wdata),
      .dmem_rdata       (dmem_rdata),
      .dmem_ready       (dmem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  flag;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] rdata;
      logic        stall;
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [1:0]  exc;
      logic [31:0] rd;
      logic [4:0]  fo;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic clear_inputs();
      MEM_Flag      = 5'b00000;
      MEM_ALUResult = '0;
      MEM_WriteData = '0;
      MEM_WriteReg  = 5'd0;
      MEM_Size      = 2'b00;
      MEM_Unsigned  = 1'b0;
      dmem_rdata    = '0;
      dmem_ready    = 1'b0;
   endtask

   task automatic set_access(input logic [4:0] flag, input logic [31:0] alu,
                             input logic [31:0] wd, input logic [1:0] size, input logic uns);
      MEM_Flag      = flag;
      MEM_ALUResult = alu;
      MEM_WriteData = wd;
      MEM_Size      = size;
      MEM_Unsigned  = uns;
   endtask

   // Watchdog: the bench must never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int req_cnt;
      int stall_cnt;
      logic done_seen;

      // flag, alu, wd, size, uns, rdata, stall, req, we, be, wdata, exc, rd, fo
      vecs[0]  = '{5'b00001, 32'h1234, 32'h0, 2'b10, 1'b0, 32'h0,
                   1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 2'b00, 32'h0, 5'b00001};
      vecs[1]  = '{5'b10101, 32'h103, 32'h0, 2'b00, 1'b0, 32'h80FF_0000,
                   1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 2'b00, 32'hFFFF_FF80, 5'b10101};
      vecs[2]  = '{5'b10101, 32'h103, 32'h0, 2'b00, 1'b1, 32'h80FF_0000,
                   1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 2'b00, 32'h0000_0080, 5'b10101};
      vecs[3]  = '{5'b10101, 32'h202, 32'h0, 2'b01, 1'b0, 32'h8001_7FFF,
                   1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 2'b00, 32'hFFFF_8001, 5'b10101};
      vecs[4]  = '{5'b10101, 32'h200, 32'h0, 2'b01, 1'b1, 32'h1234_F00D,
                   1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 2'b00, 32'h0000_F00D, 5'b10101};
      vecs[5]  = '{5'b10101, 32'h101, 32'h0, 2'b00, 1'b0, 32'h1122_7F44,
                   1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 2'b00, 32'h0000_007F, 5'b10101};
      vecs[6]  = '{5'b10101, 32'h104, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF,
                   1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 2'b00, 32'hDEAD_BEEF, 5'b10101};
      vecs[7]  = '{5'b10101, 32'h108, 32'h0, 2'b11, 1'b0, 32'hCAFE_F00D,
                   1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 2'b00, 32'hCAFE_F00D, 5'b10101};
      vecs[8]  = '{5'b00010, 32'h302, 32'h1234_56A5, 2'b00, 1'b0, 32'h0,
                   1'b1, 1'b1, 1'b1, 4'b0100, 32'hA5A5_A5A5, 2'b00, 32'h0, 5'b00010};
      vecs[9]  = '{5'b00010, 32'h202, 32'h0000_ABCD, 2'b01, 1'b0, 32'h0,
                   1'b1, 1'b1, 1'b1, 4'b1100, 32'hABCD_ABCD, 2'b00, 32'h0, 5'b00010};
      vecs[10] = '{5'b00010, 32'h400, 32'h0102_0304, 2'b10, 1'b0, 32'h0,
                   1'b1, 1'b1, 1'b1, 4'b1111, 32'h0102_0304, 2'b00, 32'h0, 5'b00010};
      vecs[11] = '{5'b10101, 32'h101, 32'h0, 2'b10, 1'b0, 32'hFFFF_FFFF,
                   1'b1, 1'b0, 1'b0, 4'hF, 32'h0, 2'b01, 32'h0, 5'b10100};
      vecs[12] = '{5'b00010, 32'h203, 32'h0000_ABCD, 2'b01, 1'b0, 32'h0,
                   1'b1, 1'b0, 1'b0, 4'hF, 32'h0, 2'b01, 32'h0, 5'b00010};
      vecs[13] = '{5'b00110, 32'h500, 32'h55AA_55AA, 2'b10, 1'b0, 32'h0,
                   1'b1, 1'b1, 1'b1, 4'b1111, 32'h55AA_55AA, 2'b00, 32'h0, 5'b00110};
      vecs[14] = '{5'b00101, 32'h105, 32'h0, 2'b01, 1'b0, 32'hFFFF_FFFF,
                   1'b1, 1'b0, 1'b0, 4'hF, 32'h0, 2'b01, 32'h0, 5'b00100};
      vecs[15] = '{5'b00101, 32'h206, 32'h0, 2'b01, 1'b0, 32'h7FFF_0000,
                   1'b1, 1'b1, 1'b0, 4'hF, 32'h0, 2'b00, 32'h0000_7FFF, 5'b00101};

      // Reset state.
      rst_n = 1'b0;
      clear_inputs();
      #12;
      chk("reset_req", 32'(dmem_req), 32'h0);
      chk("reset_we", 32'(dmem_we), 32'h0);
      chk("reset_stall", 32'(MEM_Stall), 32'h0);
      chk("reset_rdata", MEM_ReadDataMem, 32'h0);
      chk("reset_exc", 32'(MEM_Exc), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single accesses; the bus returns ready immediately.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         set_access(vecs[i].flag, vecs[i].alu, vecs[i].wd, vecs[i].size, vecs[i].uns);
         MEM_WriteReg = 5'(i + 3);
         dmem_rdata   = vecs[i].rdata;
         dmem_ready   = 1'b1;
         #1;
         chk($sformatf("v%0d_stall", i), 32'(MEM_Stall), 32'(vecs[i].stall));
         chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'(vecs[i].req));
         chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].alu & 32'hFFFF_FFFC);
         chk($sformatf("v%0d_alu_out", i), MEM_ALUResultOut, vecs[i].alu);
         chk($sformatf("v%0d_wreg_out", i), 32'(MEM_WriteRegOut), 32'(i + 3));
         chk($sformatf("v%0d_flag_in", i), 32'(MEM_FlagOut), 32'(vecs[i].flag));
         if (vecs[i].req) begin
            chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vecs[i].we));
            chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(vecs[i].be));
            if (vecs[i].we) chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].wdata);
         end
         if (vecs[i].stall) begin
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_done_stall", i), 32'(MEM_Stall), 32'h0);
            chk($sformatf("v%0d_done_req", i), 32'(dmem_req), 32'h0);
            chk($sformatf("v%0d_exc", i), 32'(MEM_Exc), 32'(vecs[i].exc));
            chk($sformatf("v%0d_flag_out", i), 32'(MEM_FlagOut), 32'(vecs[i].fo));
            if (vecs[i].flag[2] && !vecs[i].flag[1])
               chk($sformatf("v%0d_rdata", i), MEM_ReadDataMem, vecs[i].rd);
         end
         clear_inputs();
      end

      // Signed and unsigned byte load at 0x103; ready arrives after two wait cycles in BUSY.
      for (int u = 0; u < 2; u++) begin
         @(negedge clk);
         set_access(5'b10101, 32'h103, 32'h0, 2'b00, u[0]);
         dmem_rdata = 32'h80FF_0000;
         stall_cnt  = 0;
         for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            dmem_ready = (c == 3);
            #1;
            if (MEM_Stall) stall_cnt++;
            chk($sformatf("wait%0d_c%0d_req", u, c), 32'(dmem_req), 32'h1);
            chk($sformatf("wait%0d_c%0d_addr", u, c), dmem_addr, 32'h100);
         end
         @(negedge clk);
         #1;
         chk($sformatf("wait%0d_stall_cycles", u), 32'(stall_cnt), 32'd4);
         chk($sformatf("wait%0d_done_stall", u), 32'(MEM_Stall), 32'h0);
         chk($sformatf("wait%0d_rdata", u), MEM_ReadDataMem,
             (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
         chk($sformatf("wait%0d_exc", u), 32'(MEM_Exc), 32'h0);
         clear_inputs();
      end

      // Half store to 0x202 with the request held until ready arrives.
      @(negedge clk);
      set_access(5'b00010, 32'h202, 32'h0000_ABCD, 2'b01, 1'b0);
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         dmem_ready = (c == 2);
         #1;
         chk($sformatf("hst_c%0d_req", c), 32'(dmem_req), 32'h1);
         chk($sformatf("hst_c%0d_we", c), 32'(dmem_we), 32'h1);
         chk($sformatf("hst_c%0d_be", c), 32'(dmem_be), 32'hC);
         chk($sformatf("hst_c%0d_wdata", c), dmem_wdata, 32'hABCD_ABCD);
      end
      @(negedge clk);
      #1;
      chk("hst_done_req", 32'(dmem_req), 32'h0);
      chk("hst_done_stall", 32'(MEM_Stall), 32'h0);
      clear_inputs();

      // Load that never receives ready: times out after 16 request cycles.
      @(negedge clk);
      set_access(5'b10101, 32'h600, 32'h0, 2'b10, 1'b0);
      req_cnt   = 0;
      stall_cnt = 0;
      done_seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (!MEM_Stall) begin
            done_seen = 1'b1;
            break;
         end
         stall_cnt++;
         if (dmem_req) req_cnt++;
      end
      chk("to_done_reached", 32'(done_seen), 32'h1);
      chk("to_req_cycles", 32'(req_cnt), 32'd16);
      chk("to_stall_cycles", 32'(stall_cnt), 32'd17);
      chk("to_exc", 32'(MEM_Exc), 32'h2);
      chk("to_regwrite", 32'(MEM_FlagOut), 32'b10100);
      chk("to_rdata", MEM_ReadDataMem, 32'h0);
      clear_inputs();
      MEM_Flag = 5'b00001;
      @(negedge clk);
      #1;
      chk("to_idle_stall", 32'(MEM_Stall), 32'h0);
      chk("to_idle_exc", 32'(MEM_Exc), 32'h0);
      clear_inputs();

      // Ready arriving in the timeout-compare cycle wins.
      @(negedge clk);
      set_access(5'b10101, 32'h604, 32'h0, 2'b10, 1'b0);
      dmem_rdata = 32'h0BAD_CAFE;
      for (int c = 0; c < 17; c++) begin
         if (c > 0) @(negedge clk);
         dmem_ready = (c == 16);
      end
      @(negedge clk);
      #1;
      chk("race_stall", 32'(MEM_Stall), 32'h0);
      chk("race_exc", 32'(MEM_Exc), 32'h0);
      chk("race_rdata", MEM_ReadDataMem, 32'h0BAD_CAFE);
      chk("race_flag", 32'(MEM_FlagOut), 32'b10101);
      clear_inputs();

      // Reset while BUSY abandons the access; a late ready is ignored.
      @(negedge clk);
      set_access(5'b10101, 32'h700, 32'h0, 2'b10, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstb_req", 32'(dmem_req), 32'h0);
      chk("rstb_stall", 32'(MEM_Stall), 32'h0);
      chk("rstb_rdata", MEM_ReadDataMem, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      clear_inputs();
      dmem_rdata = 32'h1234_5678;
      dmem_ready = 1'b1;
      #1;
      chk("rstb_late_stall", 32'(MEM_Stall), 32'h0);
      @(negedge clk);
      dmem_ready = 1'b0;
      #1;
      chk("rstb_late_rdata", MEM_ReadDataMem, 32'h0);
      chk("rstb_late_exc", 32'(MEM_Exc), 32'h0);
      @(negedge clk);
      set_access(5'b10101, 32'h700, 32'h0, 2'b10, 1'b0);
      dmem_ready = 1'b1;
      #1;
      chk("rstb_next_req", 32'(dmem_req), 32'h1);
      @(negedge clk);
      #1;
      chk("rstb_next_stall", 32'(MEM_Stall), 32'h0);
      chk("rstb_next_rdata", MEM_ReadDataMem, 32'h1234_5678);
      clear_inputs();

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the five-stage pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Drives a single-port data-memory bus with a req/ready handshake. Applies byte enables and lane replication to stores, and formats load data (byte, half or word; signed or unsigned).
- Stalls the pipeline until the access completes or times out.
- Produces the load data, ALU result, destination register and flag bus that the MEM/WB register captures.

Parameters:
- TIMEOUT, 16: maximum cycles spent waiting for dmem_ready before the access is aborted. Legal range is 2 to 255.

Ports:
- clk  in  1  pipeline clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MEM_Flag  in  5  control bits: [4] MemtoReg, [3] Branch, [2] MemRead, [1] MemWrite, [0] RegWrite.
- MEM_ALUResult  in  32  effective address, or the result passed through for non-memory instructions.
- MEM_WriteData  in  32  store data (rs2).
- MEM_WriteReg  in  5  destination register.
- MEM_Size  in  2  access width: 00 byte, 01 half, 10 word; 11 is treated as word.
- MEM_Unsigned  in  1  zero-extends loads when high.
- MEM_FlagOut  out  5  MEM_Flag, with bit0 forced to 0 on a misaligned or timed-out load.
- MEM_ALUResultOut  out  32  combinational pass-through of MEM_ALUResult.
- MEM_WriteRegOut  out  5  combinational pass-through of MEM_WriteReg.
- MEM_ReadDataMem  out  32  formatted load data.
- MEM_Stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM and holds MEM/WB while high.
- MEM_Exc  out  2  exception code, valid only while the access is in DONE: 01 misaligned, 10 bus timeout, 00 none.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word-aligned address, {MEM_ALUResult[31:2], 2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read data, valid when dmem_ready is high.
- dmem_ready  in  1  access complete.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE; the timeout counter clears to 0.
  - The load-data register clears to 0 and the exception register clears to 00.
  - Outputs: dmem_req=0, dmem_we=0, MEM_Stall=0, MEM_ReadDataMem=0, MEM_Exc=00.
  - A reset mid-access abandons the access; a late dmem_ready in IDLE is ignored.
- Definitions:
  - access = MEM_Flag[2] or MEM_Flag[1]. If both bits are set, the access is a write.
  - a = MEM_ALUResult[1:0].
  - Misaligned: half access with a[0]=1, or word access with a not equal to 00.
- Store lanes:
  - Byte: be = 0001 shifted left by a; wdata = the low byte replicated 4 times.
  - Half: be = 0011 shifted left by a[1]×2; wdata = the low half replicated 2 times.
  - Word: be = 1111; wdata = MEM_WriteData.
  - Loads drive be=1111 and we=0.
- Load format: select the byte rdata[8a+7:8a] or the half rdata[16a[1]+15:16a[1]], then sign-extend, or zero-extend if MEM_Unsigned is high.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - No access: MEM_Stall=0 and dmem_req=0; the instruction passes through with zero added latency.
  - Access and misaligned: no request is issued. MEM_Stall=1; next state DONE with exception 01 and load data 0.
  - Access and aligned: dmem_req=1 combinationally and MEM_Stall=1; next state BUSY and the counter loads 1.
  - If dmem_ready is high at that edge, the request completes immediately: capture data and go to DONE.
- BUSY:
  - Hold dmem_req=1 with stable addr, we, be and wdata; MEM_Stall=1.
  - On dmem_ready=1: capture the formatted load data and go to DONE with exception 00.
  - Otherwise, when the counter equals TIMEOUT: drop req and go to DONE with exception 10 and load data 0. Otherwise the counter increments.
- DONE (exactly one cycle):
  - MEM_Stall=0, dmem_req=0, and MEM_Exc drives the stored exception code.
  - The pipeline advances at this edge and MEM/WB captures the outputs; next state IDLE.
  - Back-to-back accesses therefore spend at least 2 cycles each in MEM.
- Latency: a completed access with ready arriving k cycles after the request occupies MEM for k+2 cycles.
- Write-back suppression: MEM_FlagOut[0] is forced to 0 only while in DONE with a nonzero exception on a load. Stores with exceptions are simply not committed.
- Simultaneous events:
  - dmem_ready on the same cycle as the timeout compare: ready wins.
  - dmem_ready while in IDLE or DONE: ignored.

Test Plan:
- ALU instruction (MEM_Flag=5'b00001, MEM_ALUResult=0x1234) -> MEM_Stall stays 0, no dmem_req, outputs pass through the same cycle.
- Signed byte load at address 0x103, dmem_rdata=0x80FF_0000 with ready after 2 wait cycles -> stall for 4 cycles, MEM_ReadDataMem=0xFFFF_FF80, dmem_addr=0x100. Repeat with MEM_Unsigned=1 -> 0x0000_0080.
- Half store of 0xABCD to address 0x202 -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, with req held until ready.
- Word load at address 0x101 -> no dmem_req, one stall cycle, MEM_Exc=01 in DONE, MEM_FlagOut[0]=0, data 0.
- Load with dmem_ready never asserted and TIMEOUT=16 -> req held for 16 cycles, then MEM_Exc=10, RegWrite suppressed, FSM back in IDLE.
- rst_n pulled low while in BUSY -> immediate dmem_req=0 and MEM_Stall=0; a dmem_ready on the next cycle is ignored; the next access proceeds normally.
